// File: rtl/f3m_scale_arbiter.sv
//------------------------------------------------------------------------------
// Module   : f3m_scale_arbiter
// Brief    : Two-requester arbiter in front of a GF(3^m) digit-wise scalar
//            multiplier. Optional round-robin tie break via F3M_ARB_RR_EN.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

`ifndef M
`define M 97
`endif

module f3m_scale_arbiter #(
  parameter int W = 2*`M+2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [1:0]   k0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [1:0]   k1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] result,
  output logic         busy
);

  localparam int c_DIGITS = W / 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       r_state;
  logic         r_owner;
  logic [W-1:0] r_op;
  logic [1:0]   r_k;
  logic         w_pick1;
  logic [W-1:0] w_prod;

  // Illegal encodings (11) on either side force the digit to zero.
  function automatic logic [1:0] f_gf3_mul(input logic [1:0] d, input logic [1:0] k);
    if (d == 2'b11 || k == 2'b11 || d == 2'b00 || k == 2'b00)
      return 2'b00;
    return (d == k) ? 2'b01 : 2'b10;
  endfunction

  generate
    for (genvar i = 0; i < c_DIGITS; i++) begin : g_digit
      assign w_prod[2*i +: 2] = f_gf3_mul(r_op[2*i +: 2], r_k);
    end
  endgenerate

`ifdef F3M_ARB_RR_EN
  logic r_last;

  assign w_pick1 = req1 & (~req0 | ~r_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_last <= 1'b1;
    else if (r_state == S_IDLE && (req0 | req1))
      r_last <= w_pick1;
  end
`else
  assign w_pick1 = req1 & ~req0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_op    <= '0;
      r_k     <= 2'b00;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      result  <= '0;
      busy    <= 1'b0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req0 | req1) begin
            r_owner <= w_pick1;
            r_op    <= w_pick1 ? a1 : a0;
            r_k     <= w_pick1 ? k1 : k0;
            gnt0    <= ~w_pick1;
            gnt1    <= w_pick1;
            busy    <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          result  <= w_prod;
          done0   <= ~r_owner;
          done1   <= r_owner;
          r_state <= S_DONE;
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/f3m_scale_arbiter.md
F3M_SCALE_ARBITER -- requirements
Module: f3m_scale_arbiter

Interface
REQ-001 The block SHALL use `M` (97); element width W = 2*`M+2 (196 bits); each GF(3) digit is 2 bits (00=0, 01=1, 10=2, 11=illegal).
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0  input  1  requester 0 operation request; level, held until gnt0.
REQ-005 a0  input  W  requester 0 GF(3^m) operand.
REQ-006 k0  input  2  requester 0 GF(3) scalar.
REQ-007 req1, a1, k1  input  1/W/2  requester 1 equivalents of req0, a0, k0.
REQ-008 gnt0, gnt1  output  1  one-cycle grant pulse; operand and scalar captured.
REQ-009 done0, done1  output  1  one-cycle completion pulse to the owning requester.
REQ-010 result  output  W  registered scalar product; valid when a done pulse is high.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-013 IDLE: with no request the state SHALL remain IDLE; with any request, at the edge the winner's a/k SHALL be latched, owner recorded, state SHALL go to CALC.
REQ-014 gnt of the winner SHALL be high for exactly the CALC cycle; the loser's gnt SHALL stay low.
REQ-015 CALC: at the edge result SHALL load the digit-wise GF(3) product of the latched operand and scalar; state SHALL go to DONE.
REQ-016 DONE: the owner's done SHALL be high for exactly one cycle; state SHALL then return to IDLE.
REQ-017 Latency: request sampled at edge n -> gnt in cycle n+1 -> done in cycle n+2 -> next arbitration at edge n+3; maximum throughput one operation per 3 cycles.
REQ-018 Digit product SHALL be 0*x=0, 1*1=1, 1*2=2, 2*2=1; any digit or scalar equal to 11 SHALL yield 00 for that digit.
REQ-019 result SHALL hold its value from DONE until the next CALC edge.
REQ-020 Requests arriving during CALC or DONE SHALL be ignored until IDLE; a req held high through DONE SHALL be a new request.
REQ-021 Operand and scalar inputs SHALL be ignored outside the IDLE capture edge.
REQ-022 Simultaneous req0 and req1 SHALL be resolved per REQ-026/REQ-027.

Reset
REQ-023 On reset asserted the FSM SHALL enter IDLE immediately; gnt0/1, done0/1 and busy SHALL be 0; result SHALL be all zero; owner SHALL be 0.
REQ-024 Reset in CALC or DONE SHALL abandon the operation with no done pulse; the request SHALL be reissued by the requester.
REQ-025 The round-robin pointer SHALL reset to "last served = 1", so requester 0 wins the first tie.

Configuration
REQ-026 With F3M_ARB_RR_EN defined: on a tie the requester not served last SHALL win; the pointer SHALL update on every grant.
REQ-027 Without F3M_ARB_RR_EN: requester 0 SHALL always win a tie; no pointer state SHALL exist.

Verification
REQ-028 req0=1, a0=all digits 01, k0=10, req1=0 -> gnt0 pulse cycle 1, done0 cycle 2, result=all digits 10, busy high cycles 1-2.
REQ-029 req0=req1=1 held, a0=all 01, k0=01, a1=all 10, k1=10 (RR_EN) -> order 0,1,0,1, each 3 cycles apart; results alternate all-01 / all-01 (2*2=1).
REQ-030 Same stimulus without RR_EN, req0 held -> only gnt0/done0 pulses; gnt1 never asserted.
REQ-031 a0 digit pattern 11,10,01,00 repeating, k0=11 -> result all zero; k0=01 -> 11 digits become 00, others unchanged.
REQ-032 Assert reset for one cycle during CALC -> no done0, result=0, busy=0; reissued req0 completes normally with correct result.
